vc_arbiter: RTL
===============

# vc_arbiter

Output-side scheduler of the QoS path. It shares the single read-to-write path between the two virtual-channel FIFOs, VC0 (high priority) and VC1. It pops one word per cycle from the winning VC FIFO and routes it to destination FIFO D0 or D1 by a data bit. It honours the almost-full pause flags produced by the D-FIFO threshold logic and is enabled by the top-level init/idle/active control FSM.

## Interface
- BW, 6, data word width
- STARVE_MAX, 4, consecutive VC0 grants before VC1 is forced; used only with the starvation guard
- clk  in  1  clock, rising edge
- reset_L  in  1  asynchronous reset, active low
- enable  in  1  high while the control FSM is in its active state
- VC0_empty, VC1_empty  in  1  VC FIFO empty flags
- VC0_data, VC1_data  in  BW  VC FIFO read data, valid the cycle after a read
- D0_pause, D1_pause  in  1  destination FIFO almost-full (threshold) flags
- VC0_rd, VC1_rd  out  1  VC FIFO pops, combinational
- D0_wr, D1_wr  out  1  destination FIFO writes, registered
- D_data_out  out  BW  word to destination FIFOs, registered
- arb_state  out  2  FSM state, registered
- arb_idle  out  1  high when there are no grants and no words in flight

## Operation
- Grant rule, combinational: go = enable & ~D0_pause & ~D1_pause & state≠DRAIN.
  - VC0_rd = go & ~VC0_empty & ~force1.
  - VC1_rd = go & ~VC1_empty & (VC0_empty | force1).
  - VC0_rd and VC1_rd are never high together.
- Both pause flags gate every grant, because the destination is unknown before the read. The D-FIFO thresholds must leave at least 2 free entries for words in flight.
- Routing: D_data_out[BW-2] = 0 writes D0; 1 writes D1. The word passes unmodified.
- Pipeline: stage 1 registers the source select and valid on each grant. In the next cycle, stage 2 latches the selected VCx_data into D_data_out and asserts the matching Dx_wr for exactly one cycle.
- FSM, in arb_state encoding:
  - IDLE=0: enable low, pipeline empty.
  - RUN=1: a grant issued this cycle.
  - STALL=2: enable high but no grant (pause active or both VCs empty).
  - DRAIN=3: enable fell while words were in flight.
- FSM transitions:
  - IDLE→RUN/STALL when enable rises.
  - RUN↔STALL each cycle per the grant outcome.
  - RUN/STALL→DRAIN when enable falls with the pipeline non-empty; →IDLE if it is empty.
  - DRAIN→IDLE once both stages are empty.
  - DRAIN ignores enable re-assertion until it reaches IDLE.
- arb_idle = (state∈{IDLE,STALL}) & both pipeline stages empty.
- Simultaneous events:
  - A pause rising in the same cycle as a would-be grant suppresses that grant.
  - Words already in the pipeline are always written, even under pause.
- Reset mid-operation drops in-flight words, with no write.

## Timing
- Reset values: VCx_rd=0, Dx_wr=0, D_data_out=0, arb_state=IDLE, arb_idle=1, starvation counter=0.
- Latency: VCx_rd in cycle t gives Dx_wr and D_data_out in cycle t+2.
- Throughput: one word per cycle with no bubbles while go holds and the winning VC is non-empty.
- Pause response: a grant stops in the same cycle the pause is seen high. At most 2 writes follow the last grant.
- The empty flag is sampled in the grant cycle. There is no speculative read.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter of width $clog2(STARVE_MAX+1) increments on each VC0 grant while VC1_empty=0.
  - force1 = (count==STARVE_MAX) & ~VC1_empty.
  - The counter clears on any VC1 grant, or whenever VC1_empty=1.
- ARB_STARVE_GUARD_EN not defined: force1=0 with strict VC0 priority, and no counter exists.

## Structure
- Shared package qos_pkg holds:
  - the arb_state encodings (ARB_IDLE, ARB_RUN, ARB_STALL, ARB_DRAIN);
  - the BW default;
  - the destination-bit index constant DEST_BIT = BW-2.
- One sub-module, vc_arb_pipe: the 2-stage valid/source/data register pipeline with its routing decode.
- The FSM, grant logic and starvation counter stay in vc_arbiter.

## Test plan
- Reset asserted mid-run with 2 words in flight → no Dx_wr afterwards; all outputs at reset values; arb_state=0; arb_idle=1.
- VC0 holds 0x05, enable=1 → VC0_rd at t, D0_wr=1 with D_data_out=0x05 at t+2; VC0 holds 0x13 → D1_wr with 0x13.
- VC0 holds {0x01,0x02}, VC1 holds {0x11} → write order 0x01, 0x02, 0x11, back-to-back, with D-route per bit 4.
- D1_pause high with both VCs non-empty → no VCx_rd, arb_state=STALL. Pause drops → grants resume in the same cycle.
- Guard compiled in, STARVE_MAX=4, VC0 8 words, VC1 2 words → source order 0,0,0,0,1,0,0,0,0,1. Guard compiled out → eight VC0 words first.
- Enable falls in the same cycle as the last grant (2 words in flight) → arb_state=DRAIN, both words written, then IDLE. Enable re-asserted during DRAIN is ignored.

Source files
------------

// File: rtl/qos_pkg.sv
// qos_pkg: shared types and constants for the QoS output path.
// Holds the arbiter state encodings, the default data width and the
// destination-select bit index (DEST_BIT = BW_DEFAULT-2).
package qos_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_STALL = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;
  localparam int BW_DEFAULT = 6;
  localparam int DEST_BIT = BW_DEFAULT - 2;
endpackage

// File: rtl/vc_arb_pipe.sv
// vc_arb_pipe: two-stage read-to-write pipeline of the VC arbiter.
// Ports: clk, reset_L (async, active low); vc0_rd/vc1_rd grants in;
// vc0_data/vc1_data FIFO read data (valid the cycle after a grant);
// s1_v stage-1 valid out; d0_wr/d1_wr/d_data_out registered write port.
module vc_arb_pipe import qos_pkg::*; #(
  parameter int BW = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          vc0_rd,
  input  logic          vc1_rd,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  output logic          s1_v,
  output logic          d0_wr,
  output logic          d1_wr,
  output logic [BW-1:0] d_data_out
);
  // destination bit tracks the top of the word when BW is overridden
  localparam int DB = DEST_BIT + BW - BW_DEFAULT;
  logic s1_src;
  logic [BW-1:0] word;
  assign word = s1_src ? vc1_data : vc0_data;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      s1_v <= 1'b0;
      s1_src <= 1'b0;
      d0_wr <= 1'b0;
      d1_wr <= 1'b0;
      d_data_out <= '0;
    end else begin
      s1_v <= vc0_rd | vc1_rd;
      s1_src <= vc1_rd;
      d0_wr <= s1_v & ~word[DB];
      d1_wr <= s1_v & word[DB];
      if (s1_v) d_data_out <= word;
    end
endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: shares the VC-FIFO to D-FIFO path between VC0 (priority) and VC1.
// Ports: clk, reset_L (async, active low), enable from the control FSM;
// VC0/VC1 empty flags and read data in, VC0_rd/VC1_rd combinational pops out;
// D0_pause/D1_pause almost-full flags in; D0_wr/D1_wr/D_data_out registered
// writes out (routed by data bit BW-2); arb_state and arb_idle status out.
// Optional starvation guard: define ARB_STARVE_GUARD_EN to force a VC1 grant
// after STARVE_MAX consecutive VC0 grants while VC1 is waiting.
module vc_arbiter import qos_pkg::*; #(
  parameter int BW = BW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          enable,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data,
  input  logic [BW-1:0] VC1_data,
  input  logic          D0_pause,
  input  logic          D1_pause,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic          D0_wr,
  output logic          D1_wr,
  output logic [BW-1:0] D_data_out,
  output logic [1:0]    arb_state,
  output logic          arb_idle
);
  arb_state_t state, state_nxt;
  logic go, force1, grant, s1_v, busy;
  // both pauses gate every grant: the destination is unknown until the word is read
  assign go = reset_L & enable & ~D0_pause & ~D1_pause & (state != ARB_DRAIN);
  assign VC0_rd = go & ~VC0_empty & ~force1;
  assign VC1_rd = go & ~VC1_empty & (VC0_empty | force1);
  assign grant = VC0_rd | VC1_rd;
  assign busy = s1_v | D0_wr | D1_wr;
  assign arb_state = state;
  assign arb_idle = ((state == ARB_IDLE) | (state == ARB_STALL)) & ~busy;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == ARB_DRAIN) ? (busy ? ARB_DRAIN : ARB_IDLE)
              : enable ? (grant ? ARB_RUN : ARB_STALL)
              : ((state == ARB_IDLE) | ~busy) ? ARB_IDLE : ARB_DRAIN;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= ARB_IDLE;
    else state <= state_nxt;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt;
  assign force1 = (cnt == CW'(STARVE_MAX)) & ~VC1_empty;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) cnt <= '0;
    else if (VC1_empty | VC1_rd) cnt <= '0;
    else if (VC0_rd) cnt <= cnt + CW'(1);
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force1 = 1'b0;
`endif
  vc_arb_pipe #(.BW(BW)) pipe (
    .clk(clk),
    .reset_L(reset_L),
    .vc0_rd(VC0_rd),
    .vc1_rd(VC1_rd),
    .vc0_data(VC0_data),
    .vc1_data(VC1_data),
    .s1_v(s1_v),
    .d0_wr(D0_wr),
    .d1_wr(D1_wr),
    .d_data_out(D_data_out)
  );
endmodule
